// File: rtl/rx_crc_sched.sv
// rx_crc_sched: receive-side frame sequencer for the CRC checker.
// Follows each frame from start to terminator, opens the wait_crc_check
// window, collects the checker verdict (or times out), and emits exactly one
// good/bad pulse per started frame with saturating good/bad statistics.
module rx_crc_sched #(
    parameter int CNT_W   = 16,
    parameter int CRC_LAT = 3,
    parameter int TIMEOUT = 8
) (
    input  logic             rxclk,
    input  logic             reset_n,
    input  logic             receiving,
    input  logic             get_terminator,
    input  logic [2:0]       terminator_location,
    input  logic             crc_check_valid,
    input  logic             crc_check_invalid,
    input  logic             clr_cnt,
    output logic             receiving_d1,
    output logic             receiving_d2,
    output logic             wait_crc_check,
    output logic             frame_good,
    output logic             frame_bad,
    output logic             crc_timeout,
    output logic             frame_abort,
    output logic [2:0]       last_location,
    output logic             busy,
    output logic [CNT_W-1:0] good_frame_cnt,
    output logic [CNT_W-1:0] bad_frame_cnt
);

    // The timeout must always leave room for the nominal checker latency.
    localparam int TMO  = (TIMEOUT > CRC_LAT) ? TIMEOUT : CRC_LAT + 1;
    localparam int WC_W = $clog2(TMO + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(TMO);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [WC_W-1:0] wait_cnt;
    logic            pending_start;
    logic            rx_rise;
    logic            good_nxt, bad_nxt, tmo_nxt, abort_nxt;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign rx_rise = receiving & ~receiving_d1;

    // Delayed receiving strobes, independent of the frame state.
    always_ff @(posedge rxclk or negedge reset_n) begin
        if (!reset_n) begin
            receiving_d1 <= 1'b0;
            receiving_d2 <= 1'b0;
        end else begin
            receiving_d1 <= receiving;
            receiving_d2 <= receiving_d1;
        end
    end

    // Next state and verdict decode; invalid outranks valid, any result outranks timeout.
    always_comb begin
        state_nxt = state;
        good_nxt  = 1'b0;
        bad_nxt   = 1'b0;
        tmo_nxt   = 1'b0;
        abort_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (receiving) state_nxt = RECV;
            end
            RECV: begin
                if (get_terminator) begin
                    state_nxt = WAIT;
                end else if (!receiving) begin
                    state_nxt = IDLE;
                    bad_nxt   = 1'b1;
                    abort_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (crc_check_invalid) begin
                    bad_nxt = 1'b1;
                end else if (crc_check_valid) begin
                    good_nxt = 1'b1;
                end else if (wait_cnt == WC_MAX) begin
                    bad_nxt = 1'b1;
                    tmo_nxt = 1'b1;
                end
                if (good_nxt || bad_nxt) begin
                    state_nxt = (pending_start || receiving) ? RECV : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame state, wait timer, pending back-to-back start and registered verdicts.
    always_ff @(posedge rxclk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            pending_start  <= 1'b0;
            last_location  <= 3'd0;
            frame_good     <= 1'b0;
            frame_bad      <= 1'b0;
            crc_timeout    <= 1'b0;
            frame_abort    <= 1'b0;
            busy           <= 1'b0;
            wait_crc_check <= 1'b0;
        end else begin
            state          <= state_nxt;
            frame_good     <= good_nxt;
            frame_bad      <= bad_nxt;
            crc_timeout    <= tmo_nxt;
            frame_abort    <= abort_nxt;
            busy           <= (state_nxt != IDLE);
            wait_crc_check <= (state_nxt == WAIT);
            if (state == RECV && get_terminator) begin
                last_location <= terminator_location;
                wait_cnt      <= WC_W'(1);
            end else if (state == WAIT && wait_cnt != WC_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state != WAIT || state_nxt != WAIT) begin
                pending_start <= 1'b0;
            end else if (rx_rise) begin
                pending_start <= 1'b1;
            end
        end
    end

    // Statistics; a clear beats an increment arriving in the same cycle.
    always_ff @(posedge rxclk or negedge reset_n) begin
        if (!reset_n) begin
            good_frame_cnt <= '0;
            bad_frame_cnt  <= '0;
        end else if (clr_cnt) begin
            good_frame_cnt <= '0;
            bad_frame_cnt  <= '0;
        end else begin
            if (good_nxt) good_frame_cnt <= sat_inc(good_frame_cnt);
            if (bad_nxt)  bad_frame_cnt  <= sat_inc(bad_frame_cnt);
        end
    end

endmodule

// File: tb/tb_rx_crc_sched.sv
// Testbench for rx_crc_sched: directed frame table, hand-written multi-cycle
// sequences, and random frames checked against a frame-level expectation model.
module tb_rx_crc_sched;

    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 16;

    logic             rxclk = 1'b0;
    logic             reset_n = 1'b0;
    logic             receiving = 1'b0;
    logic             get_terminator = 1'b0;
    logic [2:0]       terminator_location = 3'd0;
    logic             crc_check_valid = 1'b0;
    logic             crc_check_invalid = 1'b0;
    logic             clr_cnt = 1'b0;
    logic             receiving_d1, receiving_d2, wait_crc_check;
    logic             frame_good, frame_bad, crc_timeout, frame_abort, busy;
    logic [2:0]       last_location;
    logic [CNT_W-1:0] good_frame_cnt, bad_frame_cnt;

    // Narrow-counter instance sharing the same stimulus, for saturation checks.
    logic             s_d1, s_d2, s_wait, s_good, s_bad, s_tmo, s_abort, s_busy;
    logic [2:0]       s_loc;
    logic [1:0]       s_good_cnt, s_bad_cnt;

    rx_crc_sched #(.CNT_W(CNT_W), .CRC_LAT(3), .TIMEOUT(TIMEOUT)) dut (
        .rxclk(rxclk), .reset_n(reset_n), .receiving(receiving),
        .get_terminator(get_terminator), .terminator_location(terminator_location),
        .crc_check_valid(crc_check_valid), .crc_check_invalid(crc_check_invalid),
        .clr_cnt(clr_cnt), .receiving_d1(receiving_d1), .receiving_d2(receiving_d2),
        .wait_crc_check(wait_crc_check), .frame_good(frame_good), .frame_bad(frame_bad),
        .crc_timeout(crc_timeout), .frame_abort(frame_abort), .last_location(last_location),
        .busy(busy), .good_frame_cnt(good_frame_cnt), .bad_frame_cnt(bad_frame_cnt)
    );

    rx_crc_sched #(.CNT_W(2), .CRC_LAT(3), .TIMEOUT(TIMEOUT)) dut_s (
        .rxclk(rxclk), .reset_n(reset_n), .receiving(receiving),
        .get_terminator(get_terminator), .terminator_location(terminator_location),
        .crc_check_valid(crc_check_valid), .crc_check_invalid(crc_check_invalid),
        .clr_cnt(clr_cnt), .receiving_d1(s_d1), .receiving_d2(s_d2),
        .wait_crc_check(s_wait), .frame_good(s_good), .frame_bad(s_bad),
        .crc_timeout(s_tmo), .frame_abort(s_abort), .last_location(s_loc),
        .busy(s_busy), .good_frame_cnt(s_good_cnt), .bad_frame_cnt(s_bad_cnt)
    );

    always #5 rxclk = ~rxclk;

    int cyc = 0;
    always @(posedge rxclk) cyc <= cyc + 1;

    // Verdict monitor: codes 1 good, 2 crc bad, 3 timeout, 4 abort, 9 good+bad.
    int v_total = 0, v_code = 0, v_cyc = 0, w_total = 0;
    always @(negedge rxclk) begin
        if (frame_good || frame_bad) begin
            v_total = v_total + 1;
            v_cyc   = cyc;
            if (frame_good && frame_bad) v_code = 9;
            else if (frame_good)         v_code = 1;
            else if (crc_timeout)        v_code = 3;
            else if (frame_abort)        v_code = 4;
            else                         v_code = 2;
        end
        if (wait_crc_check) w_total = w_total + 1;
    end

    int n_cmp = 0, n_fail = 0;
    int exp_good = 0, exp_bad = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge rxclk);
        #1;
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    // Frame-level expectation: verdict, latency from reference cycle, wait window length.
    function automatic void model(input int term, input int kind, input int dly,
                                  output int code, output int lat, output int wt);
        if (term == 0) begin
            code = 4; lat = 1; wt = 0;
        end else if (kind != 0 && dly >= 1 && dly <= TIMEOUT) begin
            code = (kind == 1) ? 1 : 2; lat = dly + 1; wt = dly;
        end else begin
            code = 3; lat = TIMEOUT + 1; wt = TIMEOUT;
        end
    endfunction

    task automatic check_counts(input string nm);
        chk({nm, ".good_cnt"}, good_frame_cnt, exp_good);
        chk({nm, ".bad_cnt"}, bad_frame_cnt, exp_bad);
        chk({nm, ".sat_good"}, s_good_cnt, sat3(exp_good));
        chk({nm, ".sat_bad"}, s_bad_cnt, sat3(exp_bad));
    endtask

    // kind: 0 none, 1 valid, 2 invalid, 3 both; dly counted from the terminator cycle.
    task automatic do_frame(input string nm, input int len, input int term, input int loc,
                            input int kind, input int dly, input int stray,
                            input int e_code, input int e_lat, input int e_wait);
        int v0, w0, tref;
        v0 = v_total; w0 = w_total; tref = 0;
        for (int i = 0; i < len; i++) begin
            tick();
            receiving = 1'b1;
            get_terminator = (term != 0) && (i == len - 1);
            terminator_location = 3'(loc);
            if (get_terminator) tref = cyc;
        end
        tick();
        receiving = 1'b0;
        get_terminator = 1'b0;
        if (term == 0) tref = cyc;
        if (term != 0) begin
            for (int k = 1; k <= TIMEOUT + 4; k++) begin
                if (k > 1) tick();
                crc_check_valid   = ((kind == 1) || (kind == 3)) && (k == dly);
                crc_check_invalid = (kind >= 2) && (k == dly);
            end
        end
        tick();
        crc_check_valid = 1'b0; crc_check_invalid = 1'b0;
        tick();
        if (stray != 0) begin crc_check_valid = 1'b1; get_terminator = 1'b1; end
        tick();
        crc_check_valid = 1'b0; get_terminator = 1'b0;
        tick();
        @(negedge rxclk);
        if (e_code == 1) exp_good++; else exp_bad++;
        chk({nm, ".verdicts"}, v_total - v0, 1);
        chk({nm, ".code"}, v_code, e_code);
        chk({nm, ".latency"}, v_cyc - tref, e_lat);
        chk({nm, ".wait_cycles"}, w_total - w0, e_wait);
        if (term != 0) chk({nm, ".last_location"}, last_location, loc);
        check_counts(nm);
    endtask

    typedef struct {
        int len, term, loc, kind, dly;
        int e_code, e_lat, e_wait;
    } vec_t;

    initial begin
        vec_t vt[8];
        int   code, lat, wt, t0;

        vt[0] = '{10, 1, 5, 1, 3, 1, 4, 3};
        vt[1] = '{10, 1, 2, 2, 3, 2, 4, 3};
        vt[2] = '{6, 1, 7, 3, 3, 2, 4, 3};
        vt[3] = '{5, 0, 0, 0, 0, 4, 1, 0};
        vt[4] = '{4, 1, 1, 0, 0, 3, 9, 8};
        vt[5] = '{4, 1, 3, 1, 10, 3, 9, 8};
        vt[6] = '{3, 1, 6, 1, 8, 1, 9, 8};
        vt[7] = '{3, 1, 0, 2, 1, 2, 2, 1};

        // Reset state
        repeat (3) tick();
        @(negedge rxclk);
        chk("reset.outputs", {receiving_d1, receiving_d2, wait_crc_check, frame_good,
            frame_bad, crc_timeout, frame_abort, busy, last_location}, 0);
        chk("reset.good_cnt", good_frame_cnt, 0);
        chk("reset.bad_cnt", bad_frame_cnt, 0);
        tick();
        reset_n = 1'b1;
        repeat (2) tick();

        // Directed frame table
        for (int i = 0; i < 8; i++) begin
            do_frame($sformatf("vec%0d", i), vt[i].len, vt[i].term, vt[i].loc,
                     vt[i].kind, vt[i].dly, 0, vt[i].e_code, vt[i].e_lat, vt[i].e_wait);
        end

        // Back-to-back: receiving re-rises during the wait window
        tick(); receiving = 1'b1;
        tick();
        tick(); get_terminator = 1'b1; terminator_location = 3'd2; t0 = cyc;
        tick(); get_terminator = 1'b0; receiving = 1'b0;
        tick(); receiving = 1'b1;
        tick(); crc_check_valid = 1'b1;
        @(negedge rxclk);
        chk("b2b.wait_at_T3", wait_crc_check, 1);
        tick(); crc_check_valid = 1'b0;
        @(negedge rxclk);
        chk("b2b.good_at_T4", frame_good, 1);
        chk("b2b.busy_at_T4", busy, 1);
        chk("b2b.wait_off_T4", wait_crc_check, 0);
        chk("b2b.T4_cycle", cyc - t0, 4);
        tick();
        tick();
        tick(); get_terminator = 1'b1; terminator_location = 3'd6;
        tick(); get_terminator = 1'b0; receiving = 1'b0;
        tick();
        tick(); crc_check_valid = 1'b1;
        tick(); crc_check_valid = 1'b0;
        @(negedge rxclk);
        chk("b2b.second_good", frame_good, 1);
        chk("b2b.second_idle", busy, 0);
        chk("b2b.last_location", last_location, 6);
        exp_good += 2;
        repeat (2) tick();
        @(negedge rxclk);
        check_counts("b2b");

        // Short re-rise inside the wait window restarts a frame that then aborts
        tick(); receiving = 1'b1;
        tick();
        tick(); get_terminator = 1'b1; terminator_location = 3'd4;
        tick(); get_terminator = 1'b0; receiving = 1'b0;
        tick(); receiving = 1'b1;
        tick(); receiving = 1'b0;
        @(negedge rxclk);
        chk("pend.d1", receiving_d1, 1);
        chk("pend.d2", receiving_d2, 0);
        tick();
        @(negedge rxclk);
        chk("pend.d1_low", receiving_d1, 0);
        chk("pend.d2_high", receiving_d2, 1);
        tick(); crc_check_invalid = 1'b1;
        tick(); crc_check_invalid = 1'b0;
        @(negedge rxclk);
        chk("pend.bad", frame_bad && !frame_abort, 1);
        chk("pend.busy_recv", busy, 1);
        tick();
        @(negedge rxclk);
        chk("pend.abort", frame_bad && frame_abort, 1);
        exp_bad += 2;
        repeat (2) tick();
        @(negedge rxclk);
        check_counts("pend");

        // Counter clear coinciding with a good verdict
        tick(); receiving = 1'b1;
        tick();
        tick(); get_terminator = 1'b1;
        tick(); get_terminator = 1'b0; receiving = 1'b0;
        tick();
        tick(); crc_check_valid = 1'b1; clr_cnt = 1'b1;
        tick(); crc_check_valid = 1'b0; clr_cnt = 1'b0;
        @(negedge rxclk);
        chk("clr.good_pulse", frame_good, 1);
        exp_good = 0; exp_bad = 0;
        check_counts("clr");
        repeat (2) tick();

        // Random frames against the frame-level model
        for (int n = 0; n < 40; n++) begin
            int len, term, loc, kind, dly, stray;
            len   = $urandom_range(2, 8);
            term  = ($urandom_range(0, 3) != 0) ? 1 : 0;
            loc   = $urandom_range(0, 7);
            kind  = $urandom_range(0, 3);
            dly   = $urandom_range(1, 12);
            stray = $urandom_range(0, 1);
            model(term, kind, dly, code, lat, wt);
            do_frame($sformatf("rnd%0d", n), len, term, loc, kind, dly, stray, code, lat, wt);
        end

        // Asynchronous reset in the middle of a wait window
        tick(); receiving = 1'b1;
        tick(); get_terminator = 1'b1; terminator_location = 3'd4;
        tick(); get_terminator = 1'b0; receiving = 1'b0;
        tick();
        @(negedge rxclk);
        chk("rstwait.in_wait", wait_crc_check, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rstwait.outputs", {receiving_d1, receiving_d2, wait_crc_check, frame_good,
            frame_bad, crc_timeout, frame_abort, busy, last_location}, 0);
        chk("rstwait.good_cnt", good_frame_cnt, 0);
        chk("rstwait.bad_cnt", bad_frame_cnt, 0);
        exp_good = 0; exp_bad = 0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (12) tick();
        @(negedge rxclk);
        chk("rstwait.no_verdict", frame_good || frame_bad, 0);
        check_counts("rstwait");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
